// File: rtl/codec_pkg.sv
// Shared definitions for the codificador/decodificador pair: codeword layout,
// stored-entry layout and the parity rule both ends must agree on.
package codec_pkg;

  localparam int CODE_W = 5;
  localparam int DATA_W = 4;

  // Codeword {m1,m2,m3,m4,m5} = {a,b,c,d,parity}
  localparam int CW_A = 4;
  localparam int CW_B = 3;
  localparam int CW_C = 2;
  localparam int CW_D = 1;
  localparam int CW_P = 0;

  // Buffered entry {perr,a,b,c,d}
  localparam int ENT_W   = DATA_W + 1;
  localparam int ENT_ERR = DATA_W;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Returns 1 when the codeword violates the expected parity sense.
  function automatic logic parity_err(input logic [CODE_W-1:0] cw, input logic odd);
    return (^cw) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push while full is accepted
// only when a pop happens on the same edge.
module sync_fifo
  import codec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  localparam int AW   = $clog2(DEPTH),
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [OW-1:0]    occ
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  occ_state_e       r_state;

  logic             w_pop;
  logic             w_push;
  logic [OW-1:0]    w_occ_nxt;

  assign w_pop  = pop & (r_state != OCC_EMPTY);
  assign w_push = push & ((r_state != OCC_FULL) | w_pop);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop)      w_occ_nxt = r_occ + OW'(1);
    else if (w_pop && !w_push) w_occ_nxt = r_occ - OW'(1);
  end

  // r_state is the occupancy FSM; full/empty come straight from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_state  <= OCC_EMPTY;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= w_occ_nxt;
      if (w_occ_nxt == '0)                r_state <= OCC_EMPTY;
      else if (w_occ_nxt == OW'(DEPTH))   r_state <= OCC_FULL;
      else                                r_state <= OCC_PARTIAL;
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_state == OCC_FULL);
  assign empty = (r_state == OCC_EMPTY);
  assign occ   = r_occ;

endmodule

// File: rtl/decodificador.sv
// Parity-checking decoder stage: samples codewords on ready, buffers
// {perr,nibble} in a FIFO and hands them out over valid/ack.
module decodificador
  import codec_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8,
  parameter int PARITY_ODD = 0,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m1,
  input  logic             m2,
  input  logic             m3,
  input  logic             m4,
  input  logic             m5,
  input  logic             ready,
  output logic             busy,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             err,
  output logic             valid,
  input  logic             ack,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow
);

  logic [CODE_W-1:0] w_code;
  logic              w_perr;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ENT_W-1:0]  w_wdata;
  logic [ENT_W-1:0]  w_rdata;
  logic [ENT_W-1:0]  w_head;
  logic [OW-1:0]     w_occ;

  logic [CNT_W-1:0]  r_err_count;
  logic              r_overflow;

  assign w_code  = {m1, m2, m3, m4, m5};
  assign w_perr  = parity_err(w_code, PARITY_ODD != 0);
  assign w_wdata = {w_perr, w_code[CW_A], w_code[CW_B], w_code[CW_C], w_code[CW_D]};

  // Valid/ready: the head is taken on an edge with valid=1 and ack=1; a word
  // is offered on every edge with ready=1 and is accepted unless the FIFO is
  // full with no pop on that same edge, in which case it is dropped.
  assign w_pop  = ack & ~w_empty;
  assign w_push = ready & (~w_full | w_pop);
  assign w_drop = ready & w_full & ~w_pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .occ   (w_occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push && w_perr && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign valid  = (w_occ != '0);
  assign busy   = (w_occ == OW'(DEPTH));
  assign w_head = valid ? w_rdata : '0;
  assign {err, a, b, c, d} = w_head;

  assign err_count = r_err_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_decodificador.sv
// Directed bench for decodificador: a default instance plus a CNT_W=2,
// PARITY_ODD=1 instance driven by the same stimulus.
module tb_decodificador;

  logic       clk = 1'b0;
  logic       reset;
  logic       m1, m2, m3, m4, m5;
  logic       ready, ack;

  logic       busy, a, b, c, d, err, valid, overflow;
  logic [7:0] err_count;
  logic       busy2, a2, b2, c2, d2, err2, valid2, overflow2;
  logic [1:0] err_count2;

  logic [4:0] head, head2;
  logic [4:0] exp_q[$];
  logic [4:0] w_list[5];
  int         n_total = 0;
  int         n_bad   = 0;
  int         occ_m;

  assign head  = {err, a, b, c, d};
  assign head2 = {err2, a2, b2, c2, d2};

  always #5 clk = ~clk;

  decodificador #(.DEPTH(4), .CNT_W(8), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .ready(ready), .busy(busy), .a(a), .b(b), .c(c), .d(d), .err(err),
    .valid(valid), .ack(ack), .err_count(err_count), .overflow(overflow)
  );

  decodificador #(.DEPTH(4), .CNT_W(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .ready(ready), .busy(busy2), .a(a2), .b(b2), .c(c2), .d(d2), .err(err2),
    .valid(valid2), .ack(ack), .err_count(err_count2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Even-parity codeword for a nibble, and the same nibble with bad parity
  function automatic logic [4:0] cw_even(input logic [3:0] n);
    return {n, ^n};
  endfunction

  function automatic logic [4:0] cw_bad(input logic [3:0] n);
    return {n, ~^n};
  endfunction

  // Entry the default instance should present: {perr, abcd}
  function automatic logic [4:0] ent(input logic [4:0] cw);
    return {^cw, cw[4:1]};
  endfunction

  task automatic set_word(input logic [4:0] cw);
    {m1, m2, m3, m4, m5} = cw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    ready = 1'b0;
    ack   = 1'b1;
    while (exp_q.size() > 0) begin
      chk({tag, "_head"}, 32'(head), 32'(exp_q.pop_front()));
      step();
    end
    chk({tag, "_empty"}, 32'(valid), 32'(0));
  endtask

  initial begin
    // Reset held with ready active
    reset = 1'b0;
    ready = 1'b1;
    ack   = 1'b0;
    set_word(5'($urandom_range(0, 31)));
    repeat (3) step();
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_errcnt", 32'(err_count), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_head", 32'(head), 32'(0));

    // First word after release appears one edge later
    reset = 1'b1;
    set_word(cw_even(4'b0101));
    step();
    chk("first_valid", 32'(valid), 32'(1));
    chk("first_head", 32'(head), 32'(5'b0_0101));
    ready = 1'b0;
    ack   = 1'b1;
    step();
    chk("first_pop", 32'(valid), 32'(0));

    // Clean stream with continuous ack
    ready = 1'b1;
    ack   = 1'b1;
    for (int n = 0; n < 16; n++) begin
      set_word(cw_even(4'(n)));
      step();
      chk("stream_head", 32'(head), 32'(n));
      chk("stream_valid", 32'(valid), 32'(1));
    end
    ready = 1'b0;
    step();
    chk("stream_empty", 32'(valid), 32'(0));
    chk("stream_errcnt", 32'(err_count), 32'(0));

    // Single parity error word 0001_0
    ack   = 1'b0;
    ready = 1'b1;
    set_word(5'b0001_0);
    step();
    ready = 1'b0;
    chk("perr_head", 32'(head), 32'(5'b1_0001));
    chk("perr_errcnt", 32'(err_count), 32'(1));
    chk("perr_odd_head", 32'(head2), 32'(5'b0_0001));
    ack = 1'b1;
    step();
    chk("perr_pop", 32'(valid), 32'(0));

    // Fill to full, fifth word (bad parity) is dropped
    ack   = 1'b0;
    ready = 1'b1;
    occ_m = 0;
    w_list[0] = cw_even(4'd3);
    w_list[1] = cw_even(4'd9);
    w_list[2] = cw_even(4'd12);
    w_list[3] = cw_even(4'd6);
    w_list[4] = cw_bad(4'd15);
    for (int i = 0; i < 5; i++) begin
      set_word(w_list[i]);
      step();
      if (occ_m < 4) begin
        exp_q.push_back(ent(w_list[i]));
        occ_m++;
      end
      if (i == 3) begin
        chk("fill_busy4", 32'(busy), 32'(1));
        chk("fill_ovf4", 32'(overflow), 32'(0));
      end
    end
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_busy", 32'(busy), 32'(1));
    chk("ovf_errcnt", 32'(err_count), 32'(1));
    drain("ovf_drain");
    chk("ovf_sticky", 32'(overflow), 32'(1));

    // Full with simultaneous pop and push
    reset_pulse();
    chk("rst2_ovf", 32'(overflow), 32'(0));
    ack   = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_word(cw_even(4'(1 << i)));
      exp_q.push_back(ent(cw_even(4'(1 << i))));
      step();
    end
    chk("sim_busy_pre", 32'(busy), 32'(1));
    set_word(cw_even(4'd10));
    ack = 1'b1;
    step();
    void'(exp_q.pop_front());
    exp_q.push_back(ent(cw_even(4'd10)));
    chk("sim_busy", 32'(busy), 32'(1));
    chk("sim_ovf", 32'(overflow), 32'(0));
    drain("sim_drain");

    // Counter saturation on the 2-bit instance
    reset_pulse();
    ack   = 1'b1;
    ready = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      set_word(cw_even(4'(n)));
      step();
    end
    ready = 1'b0;
    step();
    chk("sat_errcnt2", 32'(err_count2), 32'(3));
    chk("sat_errcnt", 32'(err_count), 32'(0));

    // Asynchronous reset between edges with a word buffered
    ack   = 1'b0;
    ready = 1'b1;
    set_word(cw_bad(4'd7));
    step();
    ready = 1'b0;
    chk("mid_valid", 32'(valid), 32'(1));
    chk("mid_errcnt", 32'(err_count), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(valid), 32'(0));
    chk("async_errcnt", 32'(err_count), 32'(0));
    chk("async_errcnt2", 32'(err_count2), 32'(0));
    chk("async_head", 32'(head), 32'(0));
    reset = 1'b1;
    step();
    chk("post_valid", 32'(valid), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decodificador.md
Name: decodificador

Overview:
- Downstream stage of the codificador. Consumes the 5-bit codeword m1..m5, where m1..m4 are data bits a,b,c,d and m5 is the parity bit.
- Samples the codeword on the `ready` strobe, checks parity and recovers the nibble.
- Buffers decoded words in a small FIFO and presents them to the consumer through a valid/ack handshake.
- Keeps a saturating parity-error count and a sticky overflow flag for debug.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 8, width of err_count
PARITY_ODD, 0, 0 = even parity expected over m1..m5, 1 = odd

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately
m1  input  1  codeword bit, data a
m2  input  1  codeword bit, data b
m3  input  1  codeword bit, data c
m4  input  1  codeword bit, data d
m5  input  1  codeword parity bit
ready  input  1  codeword strobe; each clk edge with ready=1 offers one word
busy  output  1  FIFO full; upstream must hold ready low
a  output  1  head nibble bit a
b  output  1  head nibble bit b
c  output  1  head nibble bit c
d  output  1  head nibble bit d
err  output  1  head word failed the parity check
valid  output  1  head word present (FIFO not empty)
ack  input  1  consumer takes the head word when valid=1
err_count  output  CNT_W  number of accepted words with a parity error, saturating
overflow  output  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers and occupancy = 0
  - valid, busy, a, b, c, d, err = 0
  - err_count = 0, overflow = 0
  - a reset mid-transfer discards all buffered words.
- Parity check: perr = m1^m2^m3^m4^m5^PARITY_ODD; perr=1 means error.
- Push: at a clk edge with ready=1, if (not full) or (full and valid and ack in the same edge), write {perr, m1, m2, m3, m4} at the write pointer. The pointer wraps modulo DEPTH.
- Drop: ready=1 while full and no pop in the same edge:
  - the word is discarded and overflow is set to 1
  - overflow clears only on reset
  - dropped words never affect err_count.
- Pop: at a clk edge with valid=1 and ack=1, advance the read pointer (wraps). ack while valid=0 is ignored.
- Simultaneous push and pop: occupancy is unchanged. When occupancy is 1, the new word becomes head on the next cycle.
- Latency: a word pushed into an empty FIFO at edge N gives valid=1 with its data after edge N (1 cycle).
- Head outputs:
  - a, b, c, d, err are registered or read from storage indexed by the read pointer.
  - They are stable while valid=1 and ack=0.
  - They are 0 when valid=0.
- Occupancy: a counter 0..DEPTH; valid = (occ != 0), busy = (occ == DEPTH).
- Implicit FSM on occupancy: EMPTY -> PARTIAL on push; PARTIAL -> FULL on push-only at occ=DEPTH-1; FULL -> PARTIAL on pop; PARTIAL -> EMPTY on pop-only at occ=1.
- err_count increments by 1 on each accepted push with perr=1 and saturates at 2^CNT_W-1 (no wrap).
- ready is sampled per edge. A level held for k cycles is k words, matching codificador timing where ready qualifies a new combinational code each cycle.

Decomposition:
- Shared package codec_pkg:
  - CODE_W=5, DATA_W=4
  - parity function shared with codificador
  - codeword field indices
- One natural sub-module, sync_fifo:
  - parameters DEPTH and WIDTH=5
  - ports: push, pop, wdata, rdata, full, empty, occ
  - same clk and async active-low reset
- decodificador keeps the parity check, drop/overflow logic and the error counter.

Test Plan:
- Reset: hold reset=0, drive ready=1 with random m -> valid=0, busy=0, err_count=0, overflow=0; after release the first word appears 1 cycle later.
- Clean stream: the 16 even-parity codewords for nibbles 0000..1111 with ack=1 -> same nibbles out in order, err=0, err_count stays 0.
- Parity error: push m=0001_0, i.e. abcd=0001 with m5=0 -> a,b,c,d = 0,0,0,1, err=1, err_count=1. With PARITY_ODD=1 the same word gives err=0.
- Fill and overflow: ack=0, push 5 words with DEPTH=4 -> busy=1 after the 4th, the 5th is dropped, overflow=1; draining returns exactly words 1..4.
- Full plus simultaneous pop and push: at occ=4, ready=1 and ack=1 on the same edge -> occ stays 4, overflow stays 0, the new word emerges 4th.
- Saturation and mid-op reset: CNT_W=2, push 5 error words -> err_count=3. Asserting reset asynchronously between edges clears valid and err_count immediately.
